// File: rtl/coin_pkg.sv
// Shared definitions for the coin pulse generator: issue FSM encodings,
// coin values, default debounce length and a saturating 8-bit add.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10
    } issue_state_t;

    // 1 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

    localparam logic [7:0] COIN_5  = 8'd5;
    localparam logic [7:0] COIN_10 = 8'd10;

    // 8-bit add that clamps at 255
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge detect for one
// raw pushbutton.
//   clk, rst   : clock, async active-high reset
//   i_btn      : raw asynchronous button
//   o_rise_c   : high in the cycle whose closing edge raises the debounced
//                level (combinational from registers)
module button_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise_c
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_flip;

    assign w_diff = r_s2 ^ r_level;
    // Counter would reach DEBOUNCE_CYCLES on this edge: level follows input.
    assign w_flip = w_diff && (r_cnt == CNT_LAST);

    // Synchronizer, counter and debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_cnt   <= '0;
                r_level <= r_s2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Announce the rise as it is committed so the coin is pending one edge later
    assign o_rise_c = w_flip & r_s2;

endmodule

// File: rtl/coin_pulse_generator.sv
// Coin-acceptor front end: debounces the two coin buttons, holds at most one
// pending coin per button and issues them as serialized single-cycle pulses,
// withholding them while the vending FSM dispenses.
//   clk, rst          : clock, async active-high reset
//   btn_5, btn_10     : raw coin buttons
//   dispense          : vending FSM is dispensing, hold coins back
//   in_5, in_10       : registered single-cycle coin pulses
//   busy              : coin pending or being issued
//   coin_total [7:0]  : saturating running total (only with COIN_TOTAL_EN)
// Build option: define COIN_TOTAL_EN to add the coin_total accumulator.
module coin_pulse_generator
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_5,
    input  logic       btn_10,
    input  logic       dispense,
    output logic       in_5,
    output logic       in_10,
`ifdef COIN_TOTAL_EN
    output logic [7:0] coin_total,
`endif
    output logic       busy
);

    issue_state_t r_state;
    issue_state_t w_state_next;
    logic         r_pend_5;
    logic         r_pend_10;
    logic         r_in_5;
    logic         r_in_10;
    logic         w_rise_5;
    logic         w_rise_10;
    logic         w_in_5_next;
    logic         w_in_10_next;
    logic         w_clr_5;
    logic         w_clr_10;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_5 (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (btn_5),
        .o_rise_c (w_rise_5)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_10 (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (btn_10),
        .o_rise_c (w_rise_10)
    );

    // Issue FSM next state and pulse decode
    always_comb begin
        w_state_next = r_state;
        w_in_5_next  = 1'b0;
        w_in_10_next = 1'b0;
        w_clr_5      = 1'b0;
        w_clr_10     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!dispense) begin
                    if (r_pend_5) begin
                        w_state_next = PULSE;
                        w_in_5_next  = 1'b1;
                        w_clr_5      = 1'b1;
                    end else if (r_pend_10) begin
                        w_state_next = PULSE;
                        w_in_10_next = 1'b1;
                        w_clr_10     = 1'b1;
                    end
                end
            end
            PULSE:   w_state_next = GAP;
            GAP:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, pulse outputs and pending flags; a new rise wins over an issue clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_in_5    <= 1'b0;
            r_in_10   <= 1'b0;
            r_pend_5  <= 1'b0;
            r_pend_10 <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_in_5    <= w_in_5_next;
            r_in_10   <= w_in_10_next;
            r_pend_5  <= w_rise_5  | (r_pend_5  & ~w_clr_5);
            r_pend_10 <= w_rise_10 | (r_pend_10 & ~w_clr_10);
        end
    end

`ifdef COIN_TOTAL_EN
    logic [7:0] r_total;

    // Running total, updated on the edge that raises the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total <= 8'd0;
        end else if (w_in_5_next) begin
            r_total <= sat_add8(r_total, COIN_5);
        end else if (w_in_10_next) begin
            r_total <= sat_add8(r_total, COIN_10);
        end
    end

    assign coin_total = r_total;
`endif

    assign in_5  = r_in_5;
    assign in_10 = r_in_10;
    assign busy  = r_pend_5 | r_pend_10 | (r_state != IDLE);

endmodule

// File: doc/coin_pulse_generator.md
Name: coin_pulse_generator

Overview:
Front end between the raw coin-acceptor pushbuttons and the vending FSM's single-cycle `in_5` / `in_10` coin inputs.
- Synchronizes and debounces each button, then converts each debounced press into a single-cycle coin pulse.
- Serializes simultaneous coins, so `in_5` and `in_10` are never high in the same cycle.
- Holds coins back while the vending FSM reports `dispense`, because that FSM ignores coins in its dispense state.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronized input must differ from its debounced level before that level changes (1 ms at 50 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_5  input  1  raw 5-unit coin button, asynchronous, may bounce.
- btn_10  input  1  raw 10-unit coin button, asynchronous, may bounce.
- dispense  input  1  dispense indication fed back from the vending FSM.
- in_5  output  1  registered single-cycle 5-unit coin pulse.
- in_10  output  1  registered single-cycle 10-unit coin pulse.
- busy  output  1  high when any coin is pending or being issued.

Behaviour:
- Reset (async, active-high): all outputs 0; synchronizers, debounced levels and counters 0; pending flags cleared; FSM in IDLE. Reset mid-operation discards pending coins.
- Synchronizer: two flops per button.
- Debounce, per channel, on synchronized value s:
  - If s equals the debounced level, the counter clears.
  - Otherwise the counter increments; on the edge where it would reach DEBOUNCE_CYCLES, the level takes s and the counter clears.
  - Bounces shorter than DEBOUNCE_CYCLES produce no level change.
- Edge detect: a rising edge of the debounced level sets pend_5 / pend_10 on the next edge.
  - A rising edge while that channel's flag is already set is dropped (flag saturates at one coin).
  - A falling edge has no effect.
- Issue FSM, states IDLE, PULSE, GAP:
  - IDLE, dispense=1: stay; pending flags held.
  - IDLE, dispense=0, pend_5=1: go to PULSE, in_5 <= 1, clear pend_5. pend_5 has priority when both flags are set.
  - IDLE, dispense=0, pend_10=1 only: go to PULSE, in_10 <= 1, clear pend_10.
  - PULSE: in_x <= 0, go to GAP.
  - GAP: go to IDLE. This guarantees at least two low cycles between pulses.
  - Unreachable state encodings recover to IDLE with outputs 0.
- Latency, for a clean button held high: the coin pulse is high during the cycle following the (DEBOUNCE_CYCLES+3)th clock edge, counting from the first edge that samples the button high, provided dispense=0 and the FSM is idle.
- Simultaneous presses: in_5 is issued first; in_10 goes high 3 cycles after in_5 went high.
- Button held through reset release: treated as a fresh press and yields one coin after debounce.
- busy = pend_5 | pend_10 | (state != IDLE), combinational from registers.

Optional Feature:
- COIN_TOTAL_EN defined:
  - Adds output port coin_total [7:0].
  - coin_total adds 5 on each in_5 pulse and 10 on each in_10 pulse, updating on the same edge that raises the pulse.
  - Saturates at 255; resets to 0.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package coin_pkg holds:
  - issue FSM state encodings (IDLE=2'b00, PULSE=2'b01, GAP=2'b10);
  - coin values COIN_5=8'd5 and COIN_10=8'd10;
  - default DEBOUNCE_CYCLES.
- One sub-module, button_debounce: 2-flop synchronizer + debounce counter + rising-edge pulse output, parameterized by DEBOUNCE_CYCLES, instantiated once per button.
- Pending flags and the issue FSM stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4):
1. Assert rst mid-cycle with btn_5=1 pending -> in_5=0, in_10=0, busy=0 immediately; no pulse appears while rst is held.
2. btn_5 clean high for 20 cycles, dispense=0 -> exactly one in_5 pulse, high during the cycle after the 7th edge counted from the first sampling edge; in_10 stays 0.
3. btn_10 toggles every 2 cycles for 12 cycles, then stays high -> no pulse during the bounce; exactly one in_10 pulse 7 edges after the input becomes stable.
4. btn_5 and btn_10 rise in the same cycle -> in_5 pulse in cycle k, in_10 pulse in cycle k+3; never both high together.
5. dispense held 1 for 6 cycles covering the moment pend_10 sets -> no pulse while dispense=1; in_10 goes high on the first edge after dispense falls to 0.
6. With COIN_TOTAL_EN: presses 5, 10, 10, then enough 10s to pass 255 -> coin_total reads 5, 15, 25 …, then holds at 255.
